// File: rtl/lcd_row_if.sv
// lcd_row_if -- bundles the row-streamer's handshake and data signals.
//
// Signals:
//   row_ready      row buffer full (pulse or level; rising edge is what counts)
//   col_pos[8:0]   index of the row being displayed (0..319)
//   ram_addr[8:0]  row RAM read address
//   ram_data[7:0]  row RAM read data, valid one clk after ram_addr
//   spi_start      one-cycle request to send spi_byte
//   spi_byte[7:0]  byte to send, stable from spi_start until spi_done
//   spi_dc         0 = command byte, 1 = pixel data byte
//   spi_done       one-cycle pulse when the SPI byte finishes
//   show_row_done  one-cycle pulse when a full row has been sent
//   busy           high whenever the streamer is not idle
//
// Modports: master = the streamer, slave = the surrounding SPI/RAM/row logic.
interface lcd_row_if;
   logic       row_ready;
   logic [8:0] col_pos;
   logic [8:0] ram_addr;
   logic [7:0] ram_data;
   logic       spi_start;
   logic [7:0] spi_byte;
   logic       spi_dc;
   logic       spi_done;
   logic       show_row_done;
   logic       busy;

   modport master (
      input  row_ready, col_pos, ram_data, spi_done,
      output ram_addr, spi_start, spi_byte, spi_dc, show_row_done, busy
   );

   modport slave (
      output row_ready, col_pos, ram_data, spi_done,
      input  ram_addr, spi_start, spi_byte, spi_dc, show_row_done, busy
   );
endinterface

// File: rtl/lcd_row_streamer.sv
// lcd_row_streamer -- streams one buffered display row to an LCD over SPI.
//
// On each rising edge of row_ready a row request is latched. The streamer
// then sends a memory-write command (CMD_FIRST for row 0, CMD_NEXT for any
// other row) followed by ROW_BYTES pixel bytes read from the row RAM, and
// pulses show_row_done when the row is complete.
//
// Ports:
//   clk    single clock for all logic
//   rst_n  asynchronous active-low reset
//   bus    lcd_row_if.master (row request, RAM read port, SPI byte handshake,
//          row-done pulse and busy flag)
//
// Build option:
//   LCD_BYTE_SWAP_EN  when defined, RAM is read at counter XOR 1 so the two
//                     bytes of each RGB565 pixel go out in swapped order.
//
// All outputs are registered. spi_start/spi_byte/spi_dc are loaded in the
// CMD and DATA states and therefore appear in the first cycle of the
// following wait state. ram_addr is loaded on the transition into RD so the
// RAM has the address during RD and presents data during DATA.
module lcd_row_streamer #(
   parameter logic [8:0] ROW_BYTES = 9'd480,
   parameter logic [7:0] CMD_FIRST = 8'h2C,
   parameter logic [7:0] CMD_NEXT  = 8'h3C
) (
   input  logic          clk,
   input  logic          rst_n,
   lcd_row_if.master     bus
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CMD       = 3'd1,
      ST_CMD_WAIT  = 3'd2,
      ST_RD        = 3'd3,
      ST_DATA      = 3'd4,
      ST_DATA_WAIT = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   state_t     state_q,         state_d;
   logic       pending_q,       pending_d;
   logic       row_ready_q,     row_ready_d;
   logic [8:0] cnt_q,           cnt_d;
   logic [8:0] ram_addr_q,      ram_addr_d;
   logic [7:0] spi_byte_q,      spi_byte_d;
   logic       spi_dc_q,        spi_dc_d;
   logic       spi_start_q,     spi_start_d;
   logic       show_row_done_q, show_row_done_d;
   logic       busy_q,          busy_d;
   logic       row_rise_s;

   // Map the byte counter to a RAM address (optionally swapping pixel bytes).
   function automatic logic [8:0] addr_of(input logic [8:0] cnt);
`ifdef LCD_BYTE_SWAP_EN
      return cnt ^ 9'd1;
`else
      return cnt;
`endif
   endfunction

   assign bus.ram_addr      = ram_addr_q;
   assign bus.spi_byte      = spi_byte_q;
   assign bus.spi_dc        = spi_dc_q;
   assign bus.spi_start     = spi_start_q;
   assign bus.show_row_done = show_row_done_q;
   assign bus.busy          = busy_q;

   // Next-state, datapath and output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ram_addr_d  = ram_addr_q;
      spi_byte_d  = spi_byte_q;
      spi_dc_d    = spi_dc_q;
      spi_start_d = 1'b0;
      row_ready_d = bus.row_ready;
      row_rise_s  = bus.row_ready & ~row_ready_q;

      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               state_d = ST_CMD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (bus.col_pos == 9'd0) begin
               spi_byte_d = CMD_FIRST;
            end else begin
               spi_byte_d = CMD_NEXT;
            end
            spi_dc_d    = 1'b0;
            spi_start_d = 1'b1;
            state_d     = ST_CMD_WAIT;
         end
         ST_CMD_WAIT: begin
            if (bus.spi_done) begin
               cnt_d      = 9'd0;
               ram_addr_d = addr_of(9'd0);
               state_d    = ST_RD;
            end else begin
               state_d = ST_CMD_WAIT;
            end
         end
         ST_RD: begin
            // Address already presented; RAM data is valid next cycle.
            state_d = ST_DATA;
         end
         ST_DATA: begin
            spi_byte_d  = bus.ram_data;
            spi_dc_d    = 1'b1;
            spi_start_d = 1'b1;
            state_d     = ST_DATA_WAIT;
         end
         ST_DATA_WAIT: begin
            if (bus.spi_done) begin
               if (cnt_q == (ROW_BYTES - 9'd1)) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d      = cnt_q + 9'd1;
                  ram_addr_d = addr_of(cnt_q + 9'd1);
                  state_d    = ST_RD;
               end
            end else begin
               state_d = ST_DATA_WAIT;
            end
         end
         ST_DONE: begin
            cnt_d   = 9'd0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = 9'd0;
            state_d = ST_IDLE;
         end
      endcase

      // A pending request is consumed when IDLE launches the row; any edge
      // arriving while a request is already pending is dropped.
      if (pending_q) begin
         pending_d = (state_q != ST_IDLE);
      end else begin
         pending_d = row_rise_s;
      end

      busy_d          = (state_d != ST_IDLE);
      show_row_done_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         pending_q       <= 1'b0;
         row_ready_q     <= 1'b0;
         cnt_q           <= 9'd0;
         ram_addr_q      <= 9'd0;
         spi_byte_q      <= 8'h00;
         spi_dc_q        <= 1'b0;
         spi_start_q     <= 1'b0;
         show_row_done_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         pending_q       <= pending_d;
         row_ready_q     <= row_ready_d;
         cnt_q           <= cnt_d;
         ram_addr_q      <= ram_addr_d;
         spi_byte_q      <= spi_byte_d;
         spi_dc_q        <= spi_dc_d;
         spi_start_q     <= spi_start_d;
         show_row_done_q <= show_row_done_d;
         busy_q          <= busy_d;
      end
   end

endmodule

// File: tb/tb_lcd_row_streamer.sv
// tb_lcd_row_streamer -- self-checking bench for lcd_row_streamer.
// A RAM model and an SPI slave model run alongside the directed sequence;
// expected byte streams are built from the row rules (command byte, then
// every RAM byte in display order) and compared with what the SPI slave saw.
module tb_lcd_row_streamer;
   localparam int NBYTES = 480;
   localparam int LIMIT  = 40000;

   logic clk;
   logic rst_n;
   lcd_row_if bus_if ();

   lcd_row_streamer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] ram [0:NBYTES-1];
   logic [8:0] obs_q [$];
   logic [8:0] exp_q [$];
   int checks    = 0;
   int errors    = 0;
   int done_cnt  = 0;
   int bad_start = 0;
   int unstable  = 0;
   int dmin      = 0;
   int dmax      = 3;

   // RAM model: data for the address seen in one cycle appears the next.
   initial begin
      logic [8:0] a;
      bus_if.ram_data = 8'h00;
      forever begin
         @(negedge clk);
         a = bus_if.ram_addr;
         @(posedge clk);
         #1;
         if (a < 9'(NBYTES)) bus_if.ram_data = ram[a];
         else                bus_if.ram_data = 8'h00;
      end
   end

   // SPI slave model: records each byte, waits a random time, answers spi_done.
   initial begin
      logic [7:0] b;
      logic       dc;
      int         d;
      bit         aborted;
      bus_if.spi_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus_if.spi_start) begin
            b  = bus_if.spi_byte;
            dc = bus_if.spi_dc;
            obs_q.push_back({dc, b});
            d = $urandom_range(dmax, dmin);
            aborted = 1'b0;
            for (int k = 0; k < d; k++) begin
               @(negedge clk);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (bus_if.spi_start) bad_start++;
               if (bus_if.spi_byte !== b || bus_if.spi_dc !== dc) unstable++;
            end
            if (!aborted) begin
               @(posedge clk);
               #1 bus_if.spi_done = 1'b1;
               @(posedge clk);
               #1 bus_if.spi_done = 1'b0;
            end
         end
      end
   end

   // Row-done monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (bus_if.show_row_done === 1'b1) done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_row();
      @(posedge clk);
      #1 bus_if.row_ready = 1'b1;
      @(posedge clk);
      #1 bus_if.row_ready = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      int cyc = 0;
      while (done_cnt < target && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, done_cnt, target);
   endtask

   task automatic wait_bytes(input int n, input string tag);
      int cyc = 0;
      while (obs_q.size() < n && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, 32'(obs_q.size() >= n), 32'd1);
   endtask

   function automatic int disp_idx(input int i);
`ifdef LCD_BYTE_SWAP_EN
      return i ^ 1;
`else
      return i;
`endif
   endfunction

   // Reference: command chosen by row index, then the row's bytes in display order.
   task automatic expect_row(input logic [8:0] col);
      exp_q.push_back({1'b0, (col == 9'd0) ? 8'h2C : 8'h3C});
      for (int i = 0; i < NBYTES; i++) exp_q.push_back({1'b1, ram[disp_idx(i)]});
   endtask

   task automatic compare_stream(input string tag);
      int bad   = 0;
      int first = -1;
      int n;
      check({tag, "_len"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      check($sformatf("%s_data_first_bad_idx_%0d", tag, first), bad, 0);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic fill_ram();
      for (int i = 0; i < NBYTES; i++) ram[i] = 8'($urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ram_addr"},  bus_if.ram_addr,      32'd0);
      check({tag, "_spi_byte"},  bus_if.spi_byte,      32'd0);
      check({tag, "_spi_dc"},    bus_if.spi_dc,        32'd0);
      check({tag, "_spi_start"}, bus_if.spi_start,     32'd0);
      check({tag, "_row_done"},  bus_if.show_row_done, 32'd0);
      check({tag, "_busy"},      bus_if.busy,          32'd0);
   endtask

   initial begin
      logic [8:0] last_addr;
      last_addr = 9'(disp_idx(NBYTES - 1));
      rst_n = 1'b0;
      bus_if.row_ready = 1'b0;
      bus_if.col_pos   = 9'd0;
      fill_ram();

      // Reset values.
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", bus_if.busy, 32'd0);

      // Row 0: 2C command then the full row.
      bus_if.col_pos = 9'd0;
      pulse_row();
      wait_done(1, "row0_done");
      expect_row(9'd0);
      compare_stream("row0");
      check("row0_last_addr", bus_if.ram_addr, 32'(last_addr));
      repeat (3) @(negedge clk);
      check("row0_idle", bus_if.busy, 32'd0);
      check("row0_single_pulse", done_cnt, 32'd1);

      // Row 5: 3C command, fresh RAM contents.
      fill_ram();
      bus_if.col_pos = 9'd5;
      pulse_row();
      wait_done(2, "row5_done");
      expect_row(9'd5);
      compare_stream("row5");

      // Back-to-back: second edge queued, third dropped.
      fill_ram();
      bus_if.col_pos = 9'd0;
      pulse_row();
      wait_bytes(100, "dual_mid");
      check("dual_busy", bus_if.busy, 32'd1);
      bus_if.col_pos = 9'd12;
      pulse_row();
      repeat (3) @(negedge clk);
      pulse_row();
      wait_done(4, "dual_done");
      repeat (2000) @(negedge clk);
      check("dual_no_third_row", done_cnt, 32'd4);
      check("dual_idle", bus_if.busy, 32'd0);
      expect_row(9'd0);
      expect_row(9'd12);
      compare_stream("dual");

      // Reset in the middle of a row.
      bus_if.col_pos = 9'd3;
      pulse_row();
      wait_bytes(201, "abort_mid");
      check("abort_busy", bus_if.busy, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (600) @(negedge clk);
      check("abort_no_done", done_cnt, 32'd4);
      check("abort_idle", bus_if.busy, 32'd0);
      check("abort_no_more_bytes", 32'(obs_q.size() <= 202), 32'd1);
      obs_q.delete();
      bus_if.col_pos = 9'd4;
      pulse_row();
      wait_done(5, "after_abort_done");
      expect_row(9'd4);
      compare_stream("after_abort");

      // Slow SPI: 50 clk per byte.
      fill_ram();
      dmin = 50;
      dmax = 50;
      bus_if.col_pos = 9'd7;
      pulse_row();
      wait_done(6, "slow_done");
      expect_row(9'd7);
      compare_stream("slow");
      check("slow_last_addr", bus_if.ram_addr, 32'(last_addr));
      check("no_extra_start", bad_start, 32'd0);
      check("byte_stable", unstable, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lcd_row_streamer.md
LCD_ROW_STREAMER -- requirements
Module: lcd_row_streamer

Interface
REQ-001 Parameter ROW_BYTES, default 9'd480, bytes per displayed row (240 RGB565 pixels).
REQ-002 Parameter CMD_FIRST, default 8'h2C, LCD memory-write command sent before row 0.
REQ-003 Parameter CMD_NEXT, default 8'h3C, LCD memory-write-continue command sent before rows 1..319.
REQ-004 The clock port is clk, input, 1 bit, single clock for all logic.
REQ-005 The reset port is rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 row_ready, input, 1, row buffer full; pulse or level, rising level sampled.
REQ-007 col_pos, input, 9, index of the row being displayed (0..319).
REQ-008 ram_addr, output, 9, row RAM read address.
REQ-009 ram_data, input, 8, row RAM read data, valid one clk after ram_addr.
REQ-010 spi_start, output, 1, one-cycle request to send spi_byte.
REQ-011 spi_byte, output, 8, byte to send, stable from spi_start until spi_done.
REQ-012 spi_dc, output, 1, 0 = command byte, 1 = pixel data byte.
REQ-013 spi_done, input, 1, one-cycle pulse when the SPI byte finishes.
REQ-014 show_row_done, output, 1, one-cycle pulse when a full row has been sent.
REQ-015 busy, output, 1, high in every state except IDLE.

Function
REQ-016 States: IDLE, CMD, CMD_WAIT, RD, DATA, DATA_WAIT, DONE.
REQ-017 IDLE -> CMD when a row request is pending; pending is cleared on that transition.
REQ-018 A row_ready rising edge (registered compare) sets pending in any state, including while busy; a second edge while pending is set is dropped.
REQ-019 CMD: spi_byte = CMD_FIRST if col_pos == 0, else CMD_NEXT; spi_dc = 0; spi_start = 1 for exactly one cycle; -> CMD_WAIT.
REQ-020 CMD_WAIT: hold spi_byte and spi_dc; on spi_done -> RD with byte counter = 0.
REQ-021 RD: drive ram_addr from the byte counter; -> DATA next cycle (1-cycle RAM latency).
REQ-022 DATA: spi_byte = ram_data, spi_dc = 1, spi_start pulse; -> DATA_WAIT.
REQ-023 DATA_WAIT: on spi_done, if counter == ROW_BYTES-1 -> DONE, else counter + 1 and -> RD.
REQ-024 Counter is 9 bits, never exceeds ROW_BYTES-1, and is reset to 0 in DONE.
REQ-025 DONE: show_row_done = 1 for one cycle; -> IDLE.
REQ-026 spi_done outside CMD_WAIT/DATA_WAIT is ignored.
REQ-027 Row period = 481 SPI transfers plus 2 clk per data byte plus 3 clk overhead.

Reset
REQ-028 While rst_n = 0: state IDLE, pending = 0, counter = 0, ram_addr = 0, spi_byte = 8'h00, spi_dc = 0, spi_start = 0, show_row_done = 0, busy = 0.
REQ-029 Asserting reset mid-row aborts the row immediately with no show_row_done; after release the block waits for a new row_ready edge.

Configuration
REQ-030 Macro LCD_BYTE_SWAP_EN: when defined, ram_addr = counter XOR 9'd1, so each pixel's two bytes are sent in swapped order; when undefined, ram_addr = counter.

Verification
REQ-031 Reset, then row_ready with col_pos = 0 -> first spi_byte 8'h2C with dc = 0, then 480 data bytes equal to RAM[0..479] with dc = 1, then one show_row_done pulse.
REQ-032 col_pos = 5, row_ready -> command byte 8'h3C, followed by 480 data bytes.
REQ-033 A second row_ready while the first row is streaming -> exactly one additional row, starting right after DONE; a third edge during the same row is dropped.
REQ-034 rst_n = 0 after data byte 200 -> all outputs return to their reset values; no show_row_done pulse; idle until the next row_ready.
REQ-035 With LCD_BYTE_SWAP_EN defined -> data order RAM[1], RAM[0], RAM[3], RAM[2] ... RAM[479], RAM[478].
REQ-036 spi_done held 50 clk late per byte -> no extra spi_start, spi_byte stable while waiting, counter ends at 479 before DONE.
